// File: rtl/tpu_skew_feeder_pkg.sv
// Shared types and default sizing for the systolic operand feeder.
// Operand words are opaque bit patterns and are never interpreted.
package tpu_pkg;
  localparam int BITS_AB = 32;
  localparam int DIM     = 8;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} feeder_state_t;
  typedef logic [BITS_AB-1:0] operand_t;
endpackage

// File: rtl/tpu_skew_feeder_if.sv
// Host write port and array-side outputs of the skew feeder.
// The master side is the host/array, the slave side is the feeder.
interface tpu_skew_feeder_if #(
  parameter int DIM     = tpu_pkg::DIM,
  parameter int BITS_AB = tpu_pkg::BITS_AB
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DIM*BITS_AB-1:0] in_vec;
  logic                   start;
  logic                   start_err;
  logic [DIM*BITS_AB-1:0] a_out;
  logic                   mac_en;
  logic                   busy;
  logic                   done;

  modport master (
    output in_valid, in_vec, start,
    input  in_ready, start_err, a_out, mac_en, busy, done
  );

  modport slave (
    input  in_valid, in_vec, start,
    output in_ready, start_err, a_out, mac_en, busy, done
  );
endinterface

// File: rtl/tpu_skew_lane.sv
// One row of the diagonal wavefront: picks vector[t-R][R] when in range, else 0.
// Purely combinational; the caller registers the result.
module tpu_skew_lane #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 32,
  parameter int R       = 0,
  parameter int TW      = 4
) (
  input  logic [TW-1:0]      t,
  input  logic [BITS_AB-1:0] col [DIM],
  output logic [BITS_AB-1:0] a
);
  always_comb begin
    a = '0;
    for (int k = 0; k < DIM; k++) begin
      if (int'(t) == R + k) a = col[k];
    end
  end
endmodule

// File: rtl/tpu_skew_feeder.sv
// Buffers DIM operand vectors, then streams them skewed by row plus a flush tail.
// Outputs are registered; in_ready stalls the host while streaming.
module tpu_skew_feeder #(
  parameter int BITS_AB = tpu_pkg::BITS_AB,
  parameter int DIM     = tpu_pkg::DIM
) (
  input logic               clk,
  input logic               rst_n,
  tpu_skew_feeder_if.slave  io
);
  import tpu_pkg::*;

  localparam int TW = $clog2(2*DIM-1);
  localparam int FW = $clog2(DIM);
  localparam int CW = $clog2(DIM+1);

  feeder_state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [FW-1:0] f_q, f_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [BITS_AB-1:0]     vbuf [DIM][DIM];
  logic [BITS_AB-1:0]     lane_a [DIM];
  logic [DIM*BITS_AB-1:0] a_d, a_q;
  logic                   in_rdy, wr_en, start_bad;
  logic                   done_q, err_q;

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    f_d       = f_q;
    cnt_d     = cnt_q;
    in_rdy    = (state_q == IDLE) && (cnt_q < CW'(DIM));
    wr_en     = in_rdy && io.in_valid;
    // Start is judged on the pre-write count, so a same-cycle final write loses.
    start_bad = (state_q == IDLE) && io.start && (cnt_q != CW'(DIM));
    case (state_q)
      IDLE: begin
        if (wr_en) cnt_d = cnt_q + CW'(1);
        if (io.start && cnt_q == CW'(DIM)) begin
          state_d = STREAM;
          t_d     = '0;
        end
      end
      STREAM: begin
        if (t_q == TW'(2*DIM-2)) begin
          state_d = FLUSH;
          f_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      FLUSH: begin
        if (f_q == FW'(DIM-2)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          f_d = f_q + FW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar r = 0; r < DIM; r++) begin : g_lane
    logic [BITS_AB-1:0] col [DIM];
    for (genvar k = 0; k < DIM; k++) begin : g_col
      assign col[k] = vbuf[k][r];
    end
    tpu_skew_lane #(.DIM(DIM), .BITS_AB(BITS_AB), .R(r), .TW(TW)) u_lane (
      .t   (t_d),
      .col (col),
      .a   (lane_a[r])
    );
  end

  // Lanes look at the next step so the registered a_out lines up with state.
  always_comb begin
    a_d = '0;
    if (state_d == STREAM) begin
      for (int r = 0; r < DIM; r++) a_d[r*BITS_AB +: BITS_AB] = lane_a[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      done_q  <= (state_q == FLUSH) && (state_d == IDLE);
      err_q   <= start_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < DIM; k++) begin
        if (cnt_q == CW'(k)) begin
          for (int r = 0; r < DIM; r++) vbuf[k][r] <= io.in_vec[r*BITS_AB +: BITS_AB];
        end
      end
    end
  end

  assign io.in_ready  = in_rdy;
  assign io.start_err = err_q;
  assign io.a_out     = a_q;
  assign io.mac_en    = (state_q != IDLE);
  assign io.busy      = (state_q != IDLE);
  assign io.done      = done_q;
endmodule

// File: doc/tpu_skew_feeder.md
Name: tpu_skew_feeder

Overview:
- Operand transmitter for the systolic TPU MAC array.
- Buffers DIM operand vectors written by the host.
- On start, drives the array's row inputs with a diagonal (skewed) wavefront: row r is delayed r cycles, so operand pairs meet in the correct MAC cell.
- Also generates the array-wide MAC enable, including the flush tail, and signals completion.

Parameters:
- BITS_AB, 32, width of one operand word (float32 bit pattern; carried opaquely, never interpreted).
- DIM, 8, array dimension: number of rows driven and number of vectors buffered per pass.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, host presents one operand vector.
- in_ready, output, 1, feeder can accept a vector.
- in_vec, input, DIM*BITS_AB, vector k; element r at bits [r*BITS_AB +: BITS_AB].
- start, input, 1, single-cycle request to stream the buffered pass.
- start_err, output, 1, one-cycle pulse when start is rejected.
- a_out, output, DIM*BITS_AB, row inputs to array column 0 (Ain of row r at slice r).
- mac_en, output, 1, enable to every MAC in the array.
- busy, output, 1, high in STREAM and FLUSH.
- done, output, 1, one-cycle pulse after the last flush cycle.

Behaviour:
- Reset values: a_out=0, mac_en=0, busy=0, done=0, start_err=0, in_ready=1, vector count=0, state=IDLE, buffer contents don't-care.
- Reset asserted mid-pass aborts immediately to these values; there is no partial done.
- States: IDLE -> STREAM -> FLUSH -> IDLE.
- IDLE:
  - in_ready = (count < DIM).
  - A handshake (in_valid & in_ready) stores in_vec as vector[count] and increments count.
  - start with count==DIM moves to STREAM next cycle, with t=0.
  - start with count<DIM is ignored and pulses start_err the next cycle.
  - Write and start in the same cycle: the write is performed. The start is evaluated against the pre-write count, so if count was DIM-1 the start is rejected.
- STREAM, t = 0 .. 2*DIM-2:
  - a_out row r = vector[t-r][r] if 0 <= t-r < DIM, else 0.
  - mac_en=1, busy=1, in_ready=0.
  - Outputs are registered: values for step t appear on the first cycle of step t.
  - After t=2*DIM-2, go to FLUSH.
- FLUSH, DIM-1 cycles:
  - a_out=0, mac_en=1, busy=1, in_ready=0.
  - Lets the last wavefront traverse all DIM columns.
  - Total mac_en high = 3*DIM-2 consecutive cycles.
- Exit:
  - Next cycle after FLUSH: state=IDLE, mac_en=0, done=1 for one cycle, count=0, in_ready=1.
  - A new vector is accepted in that same cycle.
- start while busy: ignored, no start_err.
- in_valid while in_ready=0: held by the host (no loss), no overwrite.
- Counters:
  - t width = clog2(2*DIM-1).
  - flush counter width = clog2(DIM).
  - count width = clog2(DIM+1).
  - No wrap: terminal values are compared exactly.
- No arithmetic is performed on operand data.

Decomposition:
- tpu_pkg holds:
  - BITS_AB and DIM defaults.
  - typedef enum logic [1:0] {IDLE, STREAM, FLUSH} feeder_state_t.
  - typedef logic [BITS_AB-1:0] operand_t.
- One sub-module, tpu_skew_lane: per-row r, selects vector[t-r][r] or 0 given t and r. It is instantiated DIM times via generate.

Test Plan:
- DIM=4, write vectors k=0..3 with element r = 16*k+r, then start:
  - a_out row0 = 0x00,0x10,0x20,0x30,0,0,0 at t=0..6.
  - row3 = 0,0,0,0x03,0x13,0x23,0x33.
  - mac_en high exactly 10 cycles, then done pulse once.
- Write 3 vectors, then start -> start_err pulses 1 cycle, state stays IDLE, in_ready still 1. Fourth write then start -> stream proceeds.
- Hold in_valid high with 6 vectors queued -> exactly 4 accepted, in_ready drops after the 4th, host data unchanged until done.
- Assert rst_n low at STREAM t=3 -> a_out=0, mac_en=0, busy=0 asynchronously, no done, count=0 after release.
- Pulse start during FLUSH -> ignored, no start_err, single done. Write in the done cycle -> accepted as vector 0 of the next pass.
- 4th write and start in the same cycle -> write stored, start rejected with start_err. Start next cycle -> accepted.
